// File: rtl/pipe_in_stream_buffer_pkg.sv
// Shared stream definitions: data width and block FSM state encoding.
package stream_pkg;

  // Stream word width, also used by sdram_stream_interface.
  localparam int unsigned DATA_W = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } blk_state_e;

endpackage : stream_pkg

// File: rtl/pipe_in_stream_buffer_if.sv
// Host pipe-in port plus downstream ready/valid write stream.
interface pipe_in_stream_buffer_if;
  import stream_pkg::*;

  logic              pipe_in_write;
  logic [DATA_W-1:0] pipe_in_data;
  logic              pipe_in_ready;
  logic              pipe_in_block_done;
  logic              sys_wr_ready;
  logic              sys_wr_valid;
  logic [DATA_W-1:0] sys_wr_data;

  // Host and downstream side.
  modport master (
    output pipe_in_write, pipe_in_data, sys_wr_ready,
    input  pipe_in_ready, pipe_in_block_done, sys_wr_valid, sys_wr_data
  );

  // Buffer side.
  modport slave (
    input  pipe_in_write, pipe_in_data, sys_wr_ready,
    output pipe_in_ready, pipe_in_block_done, sys_wr_valid, sys_wr_data
  );
endinterface : pipe_in_stream_buffer_if

// File: rtl/pipe_in_stream_buffer_ram.sv
// Simple dual-port RAM with registered read; the read register is the
// buffer's output data register, so it carries a synchronous reset.
module sync_fifo_ram #(
  parameter int unsigned DEPTH_WIDTH = 9,
  parameter int unsigned DATA_W      = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   we_i,
  input  logic [DEPTH_WIDTH-1:0] waddr_i,
  input  logic [DATA_W-1:0]      wdata_i,
  input  logic                   re_i,
  input  logic [DEPTH_WIDTH-1:0] raddr_i,
  output logic [DATA_W-1:0]      rdata_o
);

  logic [DATA_W-1:0] mem_q [0:(2**DEPTH_WIDTH)-1];
  logic [DATA_W-1:0] rdata_q;

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read port.
  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule : sync_fifo_ram

// File: rtl/pipe_in_stream_buffer.sv
// Block-throttled host pipe writes buffered into a ready/valid stream.
module pipe_in_stream_buffer
  import stream_pkg::*;
#(
  parameter int unsigned DEPTH_WIDTH = 9,
  parameter int unsigned BLOCK_SIZE  = 64
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  pipe_in_stream_buffer_if.slave bus,
  output logic                 fault_overflow,
  output logic [DEPTH_WIDTH:0] level
);

  localparam int unsigned DEPTH = 2**DEPTH_WIDTH;
  localparam int unsigned CNT_W = $clog2(BLOCK_SIZE + 1);

  logic [DEPTH_WIDTH-1:0] wptr_q, rptr_q;
  logic [DEPTH_WIDTH:0]   level_q, level_d;
  logic                   valid_q, valid_d;
  logic                   fault_q;
  blk_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ready_q, ready_d;
  logic                   done_q, done_d;
  logic                   blk_end;
  logic                   ram_full, ram_empty, wr_acc, rd_en;
  logic [DATA_W-1:0]      rdata;

  assign ram_full  = level_q[DEPTH_WIDTH];
  assign ram_empty = (level_q == '0);
  assign wr_acc    = bus.pipe_in_write && !ram_full;
  assign rd_en     = !ram_empty && (!valid_q || bus.sys_wr_ready);

  sync_fifo_ram #(
    .DEPTH_WIDTH (DEPTH_WIDTH),
    .DATA_W      (DATA_W)
  ) u_ram (
    .clk_i   (sys_clk),
    .rst_i   (sys_rst),
    .we_i    (wr_acc),
    .waddr_i (wptr_q),
    .wdata_i (bus.pipe_in_data),
    .re_i    (rd_en),
    .raddr_i (rptr_q),
    .rdata_o (rdata)
  );

  // RAM occupancy and output-register valid next state.
  always_comb begin
    level_d = level_q;
    case ({wr_acc, rd_en})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    valid_d = valid_q;
    if (rd_en)                              valid_d = 1'b1;
    else if (valid_q && bus.sys_wr_ready)   valid_d = 1'b0;
  end

  // Datapath state: pointers, level, output valid, sticky overflow.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      if (wr_acc) wptr_q <= wptr_q + 1'b1;
      if (rd_en)  rptr_q <= rptr_q + 1'b1;
      level_q <= level_d;
      valid_q <= valid_d;
      if (bus.pipe_in_write && ram_full) fault_q <= 1'b1;
    end
  end

  // Block FSM state register with registered host outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // Block FSM next state; every strobe counts, accepted or dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_end = 1'b0;
    if (bus.pipe_in_write) begin
      case (state_q)
        ST_IDLE: begin
          if (BLOCK_SIZE == 1) begin
            blk_end = 1'b1;
          end else begin
            state_d = ST_BURST;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_BURST: begin
          if (32'(cnt_q) + 32'd1 == BLOCK_SIZE) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            blk_end = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Block FSM outputs: ready grants a whole block of room, judged on current level.
  always_comb begin
    ready_d = (state_d == ST_IDLE) && (32'(level_q) + BLOCK_SIZE <= DEPTH);
    done_d  = blk_end;
  end

  assign bus.pipe_in_ready      = ready_q;
  assign bus.pipe_in_block_done = done_q;
  assign bus.sys_wr_valid       = valid_q;
  assign bus.sys_wr_data        = rdata;
  assign fault_overflow         = fault_q;
  assign level                  = level_q;

endmodule : pipe_in_stream_buffer

// File: tb/tb_pipe_in_stream_buffer.sv
// Directed scoreboard bench for pipe_in_stream_buffer.
module tb_pipe_in_stream_buffer;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        fault_overflow;
  logic [9:0]  level;
  logic        rdy;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned pops, gaps, done_cnt, rdy_hi;
  logic        streaming;
  logic [15:0] sb [$];

  pipe_in_stream_buffer_if bus ();

  pipe_in_stream_buffer #(
    .DEPTH_WIDTH (9),
    .BLOCK_SIZE  (64)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .bus            (bus),
    .fault_overflow (fault_overflow),
    .level          (level)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, score any transfer, advance to #1 after the edge.
  task automatic tick(input logic w, input logic [15:0] d, input logic push);
    logic [15:0] e;
    bus.pipe_in_write = w;
    bus.pipe_in_data  = d;
    bus.sys_wr_ready  = rdy;
    if (push) sb.push_back(d);
    if (bus.sys_wr_valid === 1'b1 && rdy) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("stream_data", 32'(bus.sys_wr_data), 32'(e));
        pops++;
        streaming = 1'b1;
      end
    end else if (streaming && rdy && sb.size() > 0 && bus.sys_wr_valid !== 1'b1) begin
      gaps++;
    end
    if (bus.pipe_in_block_done === 1'b1) done_cnt++;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && bus.pipe_in_ready !== 1'b1; i++) tick(1'b0, '0, 1'b0);
    chk("ready_wait", 32'(bus.pipe_in_ready), 32'd1);
  endtask

  task automatic drain(input int unsigned budget);
    rdy = 1'b1;
    for (int unsigned i = 0; i < budget && sb.size() > 0; i++) tick(1'b0, '0, 1'b0);
    chk("drain_empty", 32'(sb.size()), 32'd0);
    tick(1'b0, '0, 1'b0);
    chk("drain_valid", 32'(bus.sys_wr_valid), 32'd0);
    chk("drain_level", 32'(level), 32'd0);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    tick(1'b0, '0, 1'b0);
    sys_rst = 1'b0;
    sb.delete();
    streaming = 1'b0;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(bus.sys_wr_valid), 32'd0);
    chk("rst_data",  32'(bus.sys_wr_data), 32'd0);
    chk("rst_fault", 32'(fault_overflow), 32'd0);
    chk("rst_ready", 32'(bus.pipe_in_ready), 32'd0);
    chk("rst_done",  32'(bus.pipe_in_block_done), 32'd0);
  endtask

  initial begin
    rdy = 1'b0;
    bus.pipe_in_write = 1'b0;
    bus.pipe_in_data  = '0;
    bus.sys_wr_ready  = 1'b0;
    streaming = 1'b0;
    pops = 0; gaps = 0; done_cnt = 0;

    // 1. Reset release
    sys_rst = 1'b1;
    tick(1'b0, '0, 1'b0);
    chk("t1_rst_ready", 32'(bus.pipe_in_ready), 32'd0);
    chk("t1_rst_valid", 32'(bus.sys_wr_valid), 32'd0);
    chk("t1_rst_fault", 32'(fault_overflow), 32'd0);
    chk("t1_rst_data",  32'(bus.sys_wr_data), 32'd0);
    tick(1'b0, '0, 1'b0);
    sys_rst = 1'b0;
    chk("t1_ready_at_release", 32'(bus.pipe_in_ready), 32'd0);
    tick(1'b0, '0, 1'b0);
    chk("t1_ready_after", 32'(bus.pipe_in_ready), 32'd1);
    chk("t1_level", 32'(level), 32'd0);

    // 2. Single block with streaming downstream
    rdy = 1'b1; done_cnt = 0; gaps = 0; pops = 0; rdy_hi = 0; streaming = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      if (i == 2) chk("t2_valid_n1", 32'(bus.sys_wr_valid), 32'd0);
      if (i == 3) chk("t2_valid_n2", 32'(bus.sys_wr_valid), 32'd1);
      if (i >= 2 && bus.pipe_in_ready === 1'b1) rdy_hi++;
      tick(1'b1, 16'(i), 1'b1);
    end
    drain(20);
    chk("t2_pops", pops, 32'd64);
    chk("t2_gaps", gaps, 32'd0);
    chk("t2_ready_in_burst", rdy_hi, 32'd0);
    chk("t2_done_pulses", done_cnt, 32'd1);
    chk("t2_ready_end", 32'(bus.pipe_in_ready), 32'd1);

    // 3. Backpressure fill with ready discipline, then partial drain
    rdy = 1'b0; streaming = 1'b0;
    for (int b = 0; b < 8; b++) begin
      wait_ready();
      for (int i = 0; i < 64; i++) tick(1'b1, 16'(2000 + b * 64 + i), 1'b1);
    end
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
    chk("t3_level_full", 32'(level), 32'd511);
    chk("t3_valid", 32'(bus.sys_wr_valid), 32'd1);
    chk("t3_ready_low", 32'(bus.pipe_in_ready), 32'd0);
    chk("t3_fault", 32'(fault_overflow), 32'd0);
    rdy = 1'b1;
    for (int i = 0; i < 63; i++) tick(1'b0, '0, 1'b0);
    rdy = 1'b0;
    chk("t3_level_448", 32'(level), 32'd448);
    chk("t3_ready_lag", 32'(bus.pipe_in_ready), 32'd0);
    tick(1'b0, '0, 1'b0);
    chk("t3_ready_back", 32'(bus.pipe_in_ready), 32'd1);
    drain(600);

    // 4. Overflow ignoring ready
    rdy = 1'b0; streaming = 1'b0;
    for (int i = 1; i <= 600; i++) begin
      tick(1'b1, 16'(i), i <= 513);
      if (i == 513) chk("t4_fault_before", 32'(fault_overflow), 32'd0);
      if (i == 514) chk("t4_fault_after", 32'(fault_overflow), 32'd1);
    end
    chk("t4_level", 32'(level), 32'd512);
    pops = 0;
    drain(700);
    chk("t4_pops", pops, 32'd513);
    chk("t4_fault_sticky", 32'(fault_overflow), 32'd1);
    do_reset();

    // 5. Full RAM plus simultaneous write and read
    wait_ready();
    rdy = 1'b0;
    for (int i = 1; i <= 513; i++) tick(1'b1, 16'(1000 + i), 1'b1);
    chk("t5_level_full", 32'(level), 32'd512);
    chk("t5_fault_clear", 32'(fault_overflow), 32'd0);
    rdy = 1'b1;
    tick(1'b1, 16'hBEEF, 1'b0);
    rdy = 1'b0;
    chk("t5_fault_set", 32'(fault_overflow), 32'd1);
    chk("t5_level_511", 32'(level), 32'd511);
    drain(700);
    do_reset();

    // 6. Reset mid-burst, then a clean block
    wait_ready();
    rdy = 1'b0;
    for (int i = 1; i <= 20; i++) tick(1'b1, 16'(500 + i), 1'b0);
    chk("t6_level_pre", 32'(level), 32'd19);
    do_reset();
    tick(1'b0, '0, 1'b0);
    chk("t6_idle_ready", 32'(bus.pipe_in_ready), 32'd1);
    rdy = 1'b1; done_cnt = 0; gaps = 0; pops = 0;
    for (int i = 101; i <= 164; i++) tick(1'b1, 16'(i), 1'b1);
    drain(20);
    chk("t6_pops", pops, 32'd64);
    chk("t6_gaps", gaps, 32'd0);
    chk("t6_done", done_cnt, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pipe_in_stream_buffer
